// File: rtl/seq_bcd_display.sv
// rtl/seq_bcd_display.sv - sequential binary-to-BCD converter with 7-segment encoding
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset
//   start     conversion request, only looked at while idle
//   bin_in    [BIN_W-1:0] unsigned value, captured when start is accepted
//   busy      high while a conversion is in flight
//   done      one-cycle pulse when the result registers update
//   overflow  last value did not fit in DIGITS decimal digits
//   bcd_out   [4*DIGITS-1:0] packed BCD, ones digit in [3:0]
//   seg_out   [7*DIGITS-1:0] active-low segments, ones digit in [6:0]
module seq_bcd_display #(
  parameter int BIN_W    = 11,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  state_t                state_nx;
  logic [BIN_W-1:0]      cap;
  logic [CNT_W-1:0]      cnt;
  logic [4*DIGITS-1:0]   work;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   work_nx;
  logic                  carry;
  logic                  ovf_work;
  logic [7*DIGITS-1:0]   seg_nx;
  logic                  lead;
  logic [3:0]            dig;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // One double-dabble step. The capture register is shifted left each cycle
  // so its MSB is always the bit selected by the down-counter.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    carry   = adj[4*DIGITS-1];
    work_nx = {adj[4*DIGITS-2:0], cap[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap      <= '0;
      cnt      <= '0;
      work     <= '0;
      ovf_work <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap      <= bin_in;
            cnt      <= CNT_W'(BIN_W - 1);
            work     <= '0;
            ovf_work <= 1'b0;
          end
        end
        SHIFT: begin
          work     <= work_nx;
          cap      <= cap << 1;
          cnt      <= cnt - CNT_W'(1);
          // A carry out of the top digit means the value needs more digits
          // than we keep; remember it for the whole conversion.
          ovf_work <= ovf_work | carry;
        end
        default: ;
      endcase
    end
  end

  // Segment encoding of the finished working digits. Scanning from the top,
  // zeros stay blank until the first nonzero digit; the ones digit is always lit.
  always_comb begin
    seg_nx = '1;
    lead   = 1'b1;
    dig    = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = work[4*i +: 4];
      if (ovf_work) begin
        seg_nx[7*i +: 7] = 7'b0111111;
      end else if ((BLANK_LZ != 0) && lead && (i != 0) && (dig == 4'd0)) begin
        seg_nx[7*i +: 7] = 7'b1111111;
      end else begin
        seg_nx[7*i +: 7] = seg_code(dig);
        lead             = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      seg_out  <= '1;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        bcd_out  <= work;
        seg_out  <= seg_nx;
        overflow <= ovf_work;
      end
    end
  end

endmodule

// File: doc/seq_bcd_display.md
SEQ_BCD_DISPLAY -- requirements
Module: seq_bcd_display

Interface
REQ-001 The block SHALL have parameter BIN_W, default 11, binary input width (>=1).
REQ-002 The block SHALL have parameter DIGITS, default 4, decimal digit count (>=1).
REQ-003 The block SHALL have parameter BLANK_LZ, default 1, leading-zero blanking enable (1 = blank, 0 = show zeros).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, conversion request, sampled only when busy=0.
REQ-008 The block SHALL have port bin_in, input, BIN_W, unsigned value, captured on the accepted start edge.
REQ-009 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-010 The block SHALL have port done, output, 1, single-cycle pulse marking a result update.
REQ-011 The block SHALL have port overflow, output, 1, set when the last value exceeded 10^DIGITS-1.
REQ-012 The block SHALL have port bcd_out, output, 4*DIGITS, packed BCD with digit 0 (ones) in [3:0].
REQ-013 The block SHALL have port seg_out, output, 7*DIGITS, active-low 7-segment codes with digit 0 in [6:0].

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE, and busy SHALL equal (state != IDLE).
REQ-015 In IDLE, start=1 at an edge SHALL capture bin_in, clear the digit working registers, load bit counter = BIN_W-1, and enter SHIFT.
REQ-016 Each SHIFT cycle SHALL, in order: add 3 to every working digit >=5, shift the digit chain left by one, and insert captured bit[counter] into digit 0 bit 0.
REQ-017 A 1 shifted out of the top digit's bit 3 in any SHIFT cycle SHALL set a sticky overflow flag for that conversion.
REQ-018 SHIFT SHALL last exactly BIN_W cycles, then go to DONE, which SHALL last one cycle and then return to IDLE.
REQ-019 On the DONE->IDLE edge, bcd_out, seg_out and overflow SHALL be registered and done SHALL pulse high for exactly one cycle.
REQ-020 Latency: for start accepted at edge k, done SHALL be high in the cycle after edge k+BIN_W+1; busy SHALL be high from edge k to edge k+BIN_W+1.
REQ-021 A start accepted in the same cycle that done is high SHALL begin a new conversion (back-to-back throughput BIN_W+2 cycles).
REQ-022 While busy=1, start SHALL be ignored, and bin_in changes SHALL NOT affect the conversion in flight.
REQ-023 Between completions, bcd_out, seg_out and overflow SHALL hold their last values.
REQ-024 Segment codes SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank = 1111111.
REQ-025 With BLANK_LZ=1, each digit above the most significant nonzero digit SHALL show blank, and digit 0 SHALL always be shown.
REQ-026 On overflow, every seg_out digit SHALL show dash 0111111, and bcd_out SHALL hold the truncated low DIGITS digits.

Reset
REQ-027 resetn=0 SHALL immediately force state=IDLE, busy=0, done=0, overflow=0, bcd_out=0 and seg_out all 1111111, regardless of any conversion in progress.
REQ-028 After resetn deasserts, the first start SHALL be accepted normally, with no residue from an aborted conversion.

Verification
REQ-029 BIN_W=11, DIGITS=4, bin_in=2047, start at edge k -> done high after edge k+12; bcd_out=0x2047; seg_out digits 3..0 = 0100100, 1000000, 0011001, 1111000; overflow=0.
REQ-030 bin_in=0, BLANK_LZ=1 -> bcd_out=0x0000; digit 0 = 1000000; digits 3..1 = 1111111. With BLANK_LZ=0, all digits = 1000000.
REQ-031 BIN_W=7, DIGITS=2, bin_in=127 -> overflow=1; both digits = 0111111; bcd_out=0x27. bin_in=99 -> overflow=0; bcd_out=0x99.
REQ-032 start held high with bin_in changing every cycle -> conversions complete every 13 cycles (BIN_W=11), each using the value present at its accept edge; mid-conversion starts are ignored.
REQ-033 resetn pulsed low at SHIFT cycle 5 -> outputs take reset values immediately; no done pulse occurs; the next start with 305 yields bcd_out=0x0305 and digit 3 blank.
